// File: rtl/gpu_pkg.sv
// Shared types and constants for the GPU drawing pipeline primitives.
//
// Contents:
//   raster_state_t    - circle rasteriser control states (IDLE, SPAN, STEP, FIN)
//   MODE_FILL/OUTLINE - span drawing modes (solid span vs. endpoints only)
//   span_idx_t        - index of the four symmetric spans drawn per midpoint step
//   SCREEN_*_DEFAULT  - default visible screen size used by clipping
package gpu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SPAN = 2'd1,
        STEP = 2'd2,
        FIN  = 2'd3
    } raster_state_t;

    localparam logic MODE_FILL    = 1'b0;
    localparam logic MODE_OUTLINE = 1'b1;

    typedef logic [1:0] span_idx_t;
    localparam span_idx_t SPAN_LAST = 2'd3;

    localparam int SCREEN_W_DEFAULT = 640;
    localparam int SCREEN_H_DEFAULT = 480;

endpackage

// File: rtl/span_walker.sv
// Horizontal span walker: emits the pixels of one span as a valid/ready stream.
//
// Ports:
//   clk, n_rst   - clock, asynchronous active-low reset
//   load         - strobe: start a new span (only issued while no span is pending)
//   x1, x2       - span endpoints, signed WIDTH_BITS+2, x1 <= x2
//   row          - span row (already reduced to HEIGHT_BITS)
//   mode         - MODE_FILL walks every x, MODE_OUTLINE emits x1 then x2
//   pix_ready    - sink accepts the presented pixel
//   pix_valid    - pixel available
//   x, y         - pixel coordinates (x truncated to WIDTH_BITS)
//   span_done    - the last pixel of the span transfers in this cycle
module span_walker
    import gpu_pkg::*;
#(
    parameter int WIDTH_BITS  = 10,
    parameter int HEIGHT_BITS = 9
) (
    input  logic                          clk,
    input  logic                          n_rst,
    input  logic                          load,
    input  logic signed [WIDTH_BITS+1:0]  x1,
    input  logic signed [WIDTH_BITS+1:0]  x2,
    input  logic        [HEIGHT_BITS-1:0] row,
    input  logic                          mode,
    input  logic                          pix_ready,
    output logic                          pix_valid,
    output logic        [WIDTH_BITS-1:0]  x,
    output logic        [HEIGHT_BITS-1:0] y,
    output logic                          span_done
);

    localparam int SW = WIDTH_BITS + 2;
    localparam logic signed [SW-1:0] X_INC = SW'(1);

    logic signed [SW-1:0]    x_cnt;
    logic signed [SW-1:0]    x_end;
    logic [HEIGHT_BITS-1:0]  y_q;
    logic                    mode_q;
    logic                    valid_q;

    // The counter runs at full signed width so a span that wraps after
    // truncation still terminates on the exact right endpoint.
    assign span_done = valid_q && pix_ready && (x_cnt == x_end);

    // Output register: the presented pixel only changes on a transfer or a
    // fresh load, which keeps x/y stable across back-pressure.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            x_cnt   <= '0;
            x_end   <= '0;
            y_q     <= '0;
            mode_q  <= MODE_FILL;
            valid_q <= 1'b0;
        end else if (load) begin
            x_cnt   <= x1;
            x_end   <= x2;
            y_q     <= row;
            mode_q  <= mode;
            valid_q <= 1'b1;
        end else if (valid_q && pix_ready) begin
            if (x_cnt == x_end) begin
                valid_q <= 1'b0;
            end else if (mode_q == MODE_OUTLINE) begin
                x_cnt <= x_end;
            end else begin
                x_cnt <= x_cnt + X_INC;
            end
        end
    end

    assign pix_valid = valid_q;
    assign x         = x_cnt[WIDTH_BITS-1:0];
    assign y         = y_q;

endmodule

// File: rtl/circle_raster.sv
// Midpoint circle rasteriser (filled or outline) with a valid/ready pixel output.
//
// Ports:
//   clk, n_rst          - clock, asynchronous active-low reset
//   start               - request, accepted (as a level) only in IDLE
//   mode                - MODE_FILL / MODE_OUTLINE
//   xc, yc, rad         - centre and radius
//   r_i, g_i, b_i       - draw colour, latched on accept
//   busy                - high from the cycle after accept until done
//   done                - one-cycle completion pulse
//   pix_valid/pix_ready - pixel stream handshake
//   x, y                - pixel coordinates
//   r_o, g_o, b_o       - latched colour
//
// Build option: define CIRCLE_RASTER_CLIP_EN to drop off-screen rows and
// clamp spans to [0, SCREEN_W-1]; otherwise coordinates wrap modulo the
// port widths.
module circle_raster
    import gpu_pkg::*;
#(
    parameter int WIDTH_BITS   = 10,
    parameter int HEIGHT_BITS  = 9,
    parameter int CHANNEL_BITS = 8,
    parameter int SCREEN_W     = SCREEN_W_DEFAULT,
    parameter int SCREEN_H     = SCREEN_H_DEFAULT
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic                    start,
    input  logic                    mode,
    input  logic [WIDTH_BITS-1:0]   xc,
    input  logic [HEIGHT_BITS-1:0]  yc,
    input  logic [WIDTH_BITS-1:0]   rad,
    input  logic [CHANNEL_BITS-1:0] r_i,
    input  logic [CHANNEL_BITS-1:0] g_i,
    input  logic [CHANNEL_BITS-1:0] b_i,
    output logic                    busy,
    output logic                    done,
    output logic                    pix_valid,
    input  logic                    pix_ready,
    output logic [WIDTH_BITS-1:0]   x,
    output logic [HEIGHT_BITS-1:0]  y,
    output logic [CHANNEL_BITS-1:0] r_o,
    output logic [CHANNEL_BITS-1:0] g_o,
    output logic [CHANNEL_BITS-1:0] b_o
);

    localparam int SW = WIDTH_BITS + 2;
    typedef logic signed [SW-1:0] coord_t;

    localparam coord_t C_ONE   = coord_t'(1);
    localparam coord_t C_THREE = coord_t'(3);
    localparam coord_t C_FIVE  = coord_t'(5);

    raster_state_t state, state_n;
    span_idx_t     k, k_n;
    logic          active, active_n;
    coord_t        tx, tx_n, ty, ty_n, f, f_n;
    logic          accept, load, advance;

    logic [WIDTH_BITS-1:0]   xc_q;
    logic [HEIGHT_BITS-1:0]  yc_q;
    logic                    mode_q;
    logic [CHANNEL_BITS-1:0] r_q, g_q, b_q;

    coord_t                  half, xa, xb;
    coord_t                  span_x1, span_x2;
    logic [HEIGHT_BITS-1:0]  span_row;
    logic                    span_skip, skip_dup;
    logic                    span_done;

`ifdef CIRCLE_RASTER_CLIP_EN
    localparam coord_t SCR_X_MAX = coord_t'(SCREEN_W - 1);
    localparam coord_t SCR_H_LIM = coord_t'(SCREEN_H);
    coord_t row_s;
`endif

    // Span selection for the current (tx, ty). Besides the zero-offset
    // skips, spans 2 and 3 coincide with spans 1 and 4 on the diagonal
    // (tx == ty), so they are dropped there; this also makes radius 0 a
    // single pixel.
    always_comb begin : span_select
        half     = tx;
        skip_dup = 1'b0;
        case (k)
            2'd0: begin half = tx; skip_dup = 1'b0;                      end
            2'd1: begin half = ty; skip_dup = (tx == ty);                end
            2'd2: begin half = ty; skip_dup = (tx == '0) || (tx == ty);  end
            2'd3: begin half = tx; skip_dup = (ty == '0);                end
            default: begin half = tx; skip_dup = 1'b1;                   end
        endcase
        xa = coord_t'({2'b00, xc_q}) - half;
        xb = coord_t'({2'b00, xc_q}) + half;

`ifdef CIRCLE_RASTER_CLIP_EN
        case (k)
            2'd0:    row_s = coord_t'({{(SW-HEIGHT_BITS){1'b0}}, yc_q}) + ty;
            2'd1:    row_s = coord_t'({{(SW-HEIGHT_BITS){1'b0}}, yc_q}) + tx;
            2'd2:    row_s = coord_t'({{(SW-HEIGHT_BITS){1'b0}}, yc_q}) - tx;
            default: row_s = coord_t'({{(SW-HEIGHT_BITS){1'b0}}, yc_q}) - ty;
        endcase
        span_row  = row_s[HEIGHT_BITS-1:0];
        span_x1   = (xa < 0) ? '0 : xa;
        span_x2   = (xb > SCR_X_MAX) ? SCR_X_MAX : xb;
        span_skip = skip_dup || (row_s < 0) || (row_s >= SCR_H_LIM) ||
                    (xb < 0) || (xa > SCR_X_MAX);
`else
        case (k)
            2'd0:    span_row = yc_q + ty[HEIGHT_BITS-1:0];
            2'd1:    span_row = yc_q + tx[HEIGHT_BITS-1:0];
            2'd2:    span_row = yc_q - tx[HEIGHT_BITS-1:0];
            default: span_row = yc_q - ty[HEIGHT_BITS-1:0];
        endcase
        span_x1   = xa;
        span_x2   = xb;
        span_skip = skip_dup;
`endif
    end

    // Control: hands each non-skipped span to the walker and waits for its
    // last transfer, then runs one midpoint update per (tx, ty) step.
    always_comb begin : fsm_next
        state_n  = state;
        k_n      = k;
        active_n = active;
        tx_n     = tx;
        ty_n     = ty;
        f_n      = f;
        accept   = 1'b0;
        load     = 1'b0;
        advance  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept   = 1'b1;
                    state_n  = SPAN;
                    k_n      = '0;
                    active_n = 1'b0;
                    tx_n     = '0;
                    ty_n     = coord_t'({2'b00, rad});
                    f_n      = C_ONE - coord_t'({2'b00, rad});
                end
            end
            SPAN: begin
                if (active) begin
                    if (span_done) begin
                        active_n = 1'b0;
                        advance  = 1'b1;
                    end
                end else if (span_skip) begin
                    advance = 1'b1;
                end else begin
                    load     = 1'b1;
                    active_n = 1'b1;
                end
                if (advance) begin
                    if (k == SPAN_LAST) begin
                        state_n = STEP;
                        k_n     = '0;
                    end else begin
                        k_n = k + 2'd1;
                    end
                end
            end
            STEP: begin
                if (f < 0) begin
                    f_n = f + tx + tx + C_THREE;
                end else begin
                    f_n  = f + ((tx - ty) <<< 1) + C_FIVE;
                    ty_n = ty - C_ONE;
                end
                tx_n    = tx + C_ONE;
                state_n = (tx_n <= ty_n) ? SPAN : FIN;
            end
            FIN: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // State, midpoint registers and the operands captured on accept.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state  <= IDLE;
            k      <= '0;
            active <= 1'b0;
            tx     <= '0;
            ty     <= '0;
            f      <= '0;
            xc_q   <= '0;
            yc_q   <= '0;
            mode_q <= MODE_FILL;
            r_q    <= '0;
            g_q    <= '0;
            b_q    <= '0;
        end else begin
            state  <= state_n;
            k      <= k_n;
            active <= active_n;
            tx     <= tx_n;
            ty     <= ty_n;
            f      <= f_n;
            if (accept) begin
                xc_q   <= xc;
                yc_q   <= yc;
                mode_q <= mode;
                r_q    <= r_i;
                g_q    <= g_i;
                b_q    <= b_i;
            end
        end
    end

    assign busy = (state == SPAN) || (state == STEP);
    assign done = (state == FIN);
    assign r_o  = r_q;
    assign g_o  = g_q;
    assign b_o  = b_q;

    span_walker #(
        .WIDTH_BITS  (WIDTH_BITS),
        .HEIGHT_BITS (HEIGHT_BITS)
    ) u_walker (
        .clk       (clk),
        .n_rst     (n_rst),
        .load      (load),
        .x1        (span_x1),
        .x2        (span_x2),
        .row       (span_row),
        .mode      (mode_q),
        .pix_ready (pix_ready),
        .pix_valid (pix_valid),
        .x         (x),
        .y         (y),
        .span_done (span_done)
    );

endmodule

// File: tb/tb_circle_raster.sv
// Testbench for circle_raster: directed and randomised circles checked
// pixel-by-pixel against a behavioural model of the midpoint algorithm.
// Honours CIRCLE_RASTER_CLIP_EN in the model when the design is built with it.
module tb_circle_raster;
    import gpu_pkg::*;

    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic       start = 1'b0;
    logic       mode = 1'b0;
    logic [9:0] xc = '0;
    logic [8:0] yc = '0;
    logic [9:0] rad = '0;
    logic [7:0] r_i = '0, g_i = '0, b_i = '0;
    logic       busy, done, pix_valid;
    logic       pix_ready = 1'b0;
    logic [9:0] x;
    logic [8:0] y;
    logic [7:0] r_o, g_o, b_o;

    int total = 0;
    int bad   = 0;
    int exp_q[$];

    circle_raster dut (
        .clk(clk), .n_rst(n_rst), .start(start), .mode(mode),
        .xc(xc), .yc(yc), .rad(rad), .r_i(r_i), .g_i(g_i), .b_i(b_i),
        .busy(busy), .done(done), .pix_valid(pix_valid), .pix_ready(pix_ready),
        .x(x), .y(y), .r_o(r_o), .g_o(g_o), .b_o(b_o)
    );

    always #5 clk = ~clk;

    // Every comparison goes through here.
    task automatic checkOutput(input string tag, input longint got, input longint want);
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL %s: got=%0d expected=%0d", tag, got, want);
        end
    endtask

    function automatic int pack_pix(input int px, input int py);
        return ((px & 1023) << 16) | (py & 511);
    endfunction

    // One horizontal span of the circle as the framebuffer should see it.
    task automatic emit_span(input int row, input int a, input int b, input logic m);
`ifdef CIRCLE_RASTER_CLIP_EN
        if (row < 0 || row >= 480) return;
        if (a < 0) a = 0;
        if (b > 639) b = 639;
        if (a > b) return;
`endif
        if (m == MODE_FILL) begin
            for (int px = a; px <= b; px++) exp_q.push_back(pack_pix(px, row));
        end else begin
            exp_q.push_back(pack_pix(a, row));
            if (b != a) exp_q.push_back(pack_pix(b, row));
        end
    endtask

    // Midpoint circle: for each octant point (tx, ty) draw the four
    // mirrored rows, leaving out rows that coincide with one already drawn
    // for this point.
    task automatic build_model(input int cx, input int cy, input int r, input logic m);
        int tx, ty, f;
        exp_q.delete();
        tx = 0; ty = r; f = 1 - r;
        do begin
            emit_span(cy + ty, cx - tx, cx + tx, m);
            if (tx != ty) emit_span(cy + tx, cx - ty, cx + ty, m);
            if (tx != 0 && tx != ty) emit_span(cy - tx, cx - ty, cx + ty, m);
            if (ty != 0) emit_span(cy - ty, cx - tx, cx + tx, m);
            if (f < 0) f = f + 2 * tx + 3;
            else begin
                f = f + 2 * (tx - ty) + 5;
                ty = ty - 1;
            end
            tx = tx + 1;
        end while (tx <= ty);
    endtask

    // Runs one circle. ready_mode: 0 always ready, 1 toggling, 2 random.
    // With hold_start the request stays high and the inputs are scrambled
    // after accept, so the operation must use only the latched values.
    task automatic applyStimulus(input int cx, input int cy, input int r, input logic m,
                                 input int ready_mode, input bit hold_start, output int npix);
        logic [7:0] cr, cg, cb;
        int  budget, cyc, e;
        bit  got_done, prev_stall;
        logic [9:0] px_prev;
        logic [8:0] py_prev;
        logic [23:0] col_prev;
        build_model(cx, cy, r, m);
        cr = 8'($urandom); cg = 8'($urandom); cb = 8'($urandom);
        xc = 10'(cx); yc = 9'(cy); rad = 10'(r); mode = m;
        r_i = cr; g_i = cg; b_i = cb;
        checkOutput("idle_busy", busy, 0);
        start = 1'b1;
        @(posedge clk); #1;
        if (!hold_start) start = 1'b0;
        else begin
            xc = 10'(cx + 300); yc = 9'(cy + 100); rad = 10'd5; mode = ~m;
            r_i = ~cr; g_i = ~cg; b_i = ~cb;
        end
        checkOutput("busy_rise", busy, 1);
        budget = 6 * exp_q.size() + 20 * (r + 2) + 50;
        cyc = 0; got_done = 0; prev_stall = 0; npix = 0;
        px_prev = '0; py_prev = '0; col_prev = '0;
        while (!got_done && cyc < budget) begin
            pix_ready = (ready_mode == 0) ? 1'b1 :
                        (ready_mode == 1) ? ~cyc[0] : 1'($urandom_range(0, 1));
            if (prev_stall) begin
                checkOutput("stall_valid", pix_valid, 1);
                checkOutput("stall_x", x, px_prev);
                checkOutput("stall_y", y, py_prev);
                checkOutput("stall_rgb", {r_o, g_o, b_o}, col_prev);
            end
            if (pix_valid && pix_ready) begin
                if (exp_q.size() == 0) checkOutput("extra_pixel", 1, 0);
                else begin
                    e = exp_q.pop_front();
                    checkOutput("pix_xy", pack_pix(int'(x), int'(y)), e);
                    checkOutput("pix_rgb", {r_o, g_o, b_o}, {cr, cg, cb});
                    npix++;
                end
            end
            prev_stall = pix_valid && !pix_ready;
            px_prev = x; py_prev = y; col_prev = {r_o, g_o, b_o};
            if (done) begin
                got_done = 1;
                checkOutput("done_pixels_left", exp_q.size(), 0);
                checkOutput("done_busy", busy, 0);
            end else begin
                @(posedge clk); #1;
                cyc++;
            end
        end
        if (!got_done) checkOutput("done_timeout", 0, 1);
        pix_ready = 1'b0;
        if (!hold_start) begin
            @(posedge clk); #1;
            checkOutput("after_busy", busy, 0);
            checkOutput("after_done", done, 0);
        end
    endtask

    initial begin
        int n, wait_cyc;
        bit saw_done, saw_busy;

        // Reset state
        #12;
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_valid", pix_valid, 0);
        checkOutput("rst_x", x, 0);
        checkOutput("rst_y", y, 0);
        checkOutput("rst_rgb", {r_o, g_o, b_o}, 0);
        @(negedge clk); n_rst = 1'b1;
        @(posedge clk); #1;

        applyStimulus(100, 50, 0, MODE_FILL, 0, 0, n);
        checkOutput("rad0_count", n, 1);
        applyStimulus(10, 10, 1, MODE_FILL, 0, 0, n);
        checkOutput("rad1_fill_count", n, 5);
        applyStimulus(10, 10, 1, MODE_OUTLINE, 0, 0, n);
        checkOutput("rad1_outline_count", n, 4);
        applyStimulus(200, 100, 3, MODE_FILL, 1, 0, n);
        checkOutput("rad3_count", n, 39);

        // Corner circle: wraps without clipping, trimmed with it
        applyStimulus(0, 0, 2, MODE_FILL, 0, 0, n);
`ifdef CIRCLE_RASTER_CLIP_EN
        checkOutput("corner_count", n, 9);
`else
        checkOutput("corner_count", n, 23);
`endif
        applyStimulus(639, 479, 3, MODE_OUTLINE, 2, 0, n);
        applyStimulus(320, 240, 60, MODE_OUTLINE, 0, 0, n);

        for (int i = 0; i < 12; i++) begin
            applyStimulus($urandom_range(0, 1023), $urandom_range(0, 511),
                          $urandom_range(0, 15), 1'($urandom_range(0, 1)),
                          $urandom_range(0, 2), 0, n);
        end

        // start held through an operation: re-accepted only after FIN
        applyStimulus(50, 60, 4, MODE_FILL, 0, 1, n);
        @(posedge clk); #1;
        checkOutput("restart_idle_busy", busy, 0);
        checkOutput("restart_idle_done", done, 0);
        @(posedge clk); #1;
        checkOutput("restart_accept_busy", busy, 1);
        wait_cyc = 0;
        while (!pix_valid && wait_cyc < 50) begin
            @(posedge clk); #1;
            wait_cyc++;
        end
        checkOutput("restart_pixel_seen", pix_valid, 1);

        // Asynchronous reset mid-span
        #2 n_rst = 1'b0;
        #1;
        checkOutput("abort_valid", pix_valid, 0);
        checkOutput("abort_busy", busy, 0);
        checkOutput("abort_done", done, 0);
        start = 1'b0;
        @(negedge clk); n_rst = 1'b1;
        saw_done = 0; saw_busy = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (done) saw_done = 1;
            if (busy) saw_busy = 1;
        end
        checkOutput("abort_no_done", saw_done, 0);
        checkOutput("abort_stays_idle", saw_busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
